// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter/receiver FSM encoding and
// the bit-period helper used to size the baud timers.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Integer division truncates, so the line runs marginally fast rather than slow.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick is high for one clock every CLKS_PER_BIT clocks,
// counted from the clock after restart was seen.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk50m,
  input  logic reset_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (restart || (cnt_reg == CNT_MAX)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Left unmasked by restart: the last stop clock must still see its tick
  // while a back-to-back handshake restarts the timer on the same edge.
  assign bit_tick = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB-first, optional
// parity, 1 or 2 stop bits, one frame per valid/ready handshake.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk50m,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 txd
);

  localparam int         CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_IDX     = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP    = 1'(STOP_BITS - 1);

  generate
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_data_bits
      $error("uart_tx_param: DATA_BITS must be 5..8");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
      $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
    end
  endgenerate

  logic [2:0]           state_reg,    state_next;
  logic [DATA_BITS-1:0] shift_reg,    shift_next;
  logic [2:0]           bit_idx_reg,  bit_idx_next;
  logic                 stop_cnt_reg, stop_cnt_next;
  logic                 parity_reg,   parity_next;
  logic                 txd_reg,      txd_next;

  logic bit_tick;
  logic handshake;
  logic load;
  logic parity_calc;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk50m  (clk50m),
    .reset_n (reset_n),
    .restart (handshake),
    .bit_tick(bit_tick)
  );

  assign tx_ready  = (state_reg == ST_IDLE) ||
                     ((state_reg == ST_STOP) && bit_tick && (stop_cnt_reg == LAST_STOP));
  assign handshake = tx_valid && tx_ready;
  assign tx_busy   = (state_reg != ST_IDLE);
  assign txd       = txd_reg;

  // Parity is taken from the word as captured, so later changes on tx_data cannot leak in.
  assign parity_calc = (PARITY == PARITY_ODD) ? ~(^tx_data) : (^tx_data);

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    stop_cnt_next = stop_cnt_reg;
    parity_next   = parity_reg;
    txd_next      = txd_reg;
    load          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        txd_next = 1'b1;
        if (handshake) begin
          load = 1'b1;
        end
      end

      ST_START: begin
        if (bit_tick) begin
          state_next   = ST_DATA;
          bit_idx_next = 3'd0;
          txd_next     = shift_reg[0];
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          if (bit_idx_reg == LAST_IDX) begin
            if (PARITY != PARITY_NONE) begin
              state_next = ST_PARITY;
              txd_next   = parity_reg;
            end else begin
              state_next    = ST_STOP;
              stop_cnt_next = 1'b0;
              txd_next      = 1'b1;
            end
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = shift_reg >> 1;
            txd_next     = shift_reg[1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_tick) begin
          state_next    = ST_STOP;
          stop_cnt_next = 1'b0;
          txd_next      = 1'b1;
        end
      end

      ST_STOP: begin
        if (bit_tick) begin
          if (stop_cnt_reg == LAST_STOP) begin
            if (handshake) begin
              load = 1'b1;
            end else begin
              state_next = ST_IDLE;
              txd_next   = 1'b1;
            end
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        txd_next   = 1'b1;
      end
    endcase

    // Same capture path for a frame from IDLE and for a back-to-back frame.
    if (load) begin
      state_next    = ST_START;
      shift_next    = tx_data;
      parity_next   = parity_calc;
      bit_idx_next  = 3'd0;
      stop_cnt_next = 1'b0;
      txd_next      = 1'b0;
    end
  end

  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_idx_reg  <= 3'd0;
      stop_cnt_reg <= 1'b0;
      parity_reg   <= 1'b0;
      txd_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      stop_cnt_reg <= stop_cnt_next;
      parity_reg   <= parity_next;
      txd_reg      <= txd_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7N2) at 434 clk/bit,
// table-driven frames plus hand-written reset and back-to-back sequences.
module tb_uart_tx_param;

  localparam int CPB = 434;

  logic       clk50m = 1'b0;
  logic       reset_n;
  logic [7:0] data_a [3];
  logic [6:0] data7;
  logic [3:0] valid_v;
  logic [3:0] ready_v;
  logic [3:0] busy_v;
  logic [3:0] txd_v;

  int checks   = 0;
  int failures = 0;

  always #10 clk50m = ~clk50m;

  uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk50m(clk50m), .reset_n(reset_n), .tx_data(data_a[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx_busy(busy_v[0]), .txd(txd_v[0]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk50m(clk50m), .reset_n(reset_n), .tx_data(data_a[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx_busy(busy_v[1]), .txd(txd_v[1]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
    .clk50m(clk50m), .reset_n(reset_n), .tx_data(data_a[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx_busy(busy_v[2]), .txd(txd_v[2]));
  uart_tx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk50m(clk50m), .reset_n(reset_n), .tx_data(data7), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .tx_busy(busy_v[3]), .txd(txd_v[3]));

  // frame bit i is the i-th bit on the line (bit 0 = start bit)
  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [11:0] frame;
    int          nbits;
    string       tag;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_data(input int sel, input logic [7:0] d);
    if (sel == 3) data7 = d[6:0];
    else data_a[sel] = d;
  endtask

  task automatic run_frame(input int sel, input logic [7:0] d, input logic [11:0] frame,
                           input int nbits, input string tag);
    int busy_errs;
    int ready_errs;
    int match;
    int first_fail;
    busy_errs  = 0;
    ready_errs = 0;
    first_fail = failures;
    @(negedge clk50m);
    chk($sformatf("%s ready before", tag), 32'(ready_v[sel]), 32'd1);
    set_data(sel, d);
    valid_v[sel] = 1'b1;
    @(posedge clk50m);
    for (int b = 0; b < nbits; b++) begin
      match = 0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk50m);
        if (b == 0 && c == 0) begin
          valid_v[sel] = 1'b0;
          set_data(sel, ~d);
        end
        if (txd_v[sel] === frame[b]) match++;
        if (busy_v[sel] !== 1'b1) busy_errs++;
        if (ready_v[sel] !== ((b == nbits - 1) && (c == CPB - 1))) ready_errs++;
      end
      chk($sformatf("%s bit%0d clocks matching", tag, b), 32'(match), 32'(CPB));
    end
    chk($sformatf("%s busy errors", tag), 32'(busy_errs), 32'd0);
    chk($sformatf("%s ready errors", tag), 32'(ready_errs), 32'd0);
    @(negedge clk50m);
    chk($sformatf("%s idle {txd,busy,ready}", tag),
        32'({txd_v[sel], busy_v[sel], ready_v[sel]}), 32'b101);
    $display("frame %s data=0x%02h bits=%0d clks=%0d %s", tag, d, nbits, nbits * CPB,
             (failures == first_fail) ? "ok" : "bad");
  endtask

  initial begin
    int bad;
    int m1;
    int m2;
    int busy_errs;
    int ready_errs;
    logic [19:0] b2b;

    vecs[0] = '{0, 8'h48, 12'h290, 10, "8N1_48"};
    vecs[1] = '{0, 8'hFF, 12'h3FE, 10, "8N1_FF"};
    vecs[2] = '{1, 8'h49, 12'h692, 11, "8E1_49"};
    vecs[3] = '{1, 8'hFF, 12'h5FE, 11, "8E1_FF"};
    vecs[4] = '{2, 8'h49, 12'h492, 11, "8O1_49"};
    vecs[5] = '{2, 8'h00, 12'h600, 11, "8O1_00"};
    vecs[6] = '{3, 8'h55, 12'h3AA, 10, "7N2_55"};
    vecs[7] = '{3, 8'h7F, 12'h3FE, 10, "7N2_7F"};

    // Reset held 10 us with every source already asserting valid.
    reset_n = 1'b0;
    valid_v = 4'hF;
    data_a[0] = 8'hA5; data_a[1] = 8'hA5; data_a[2] = 8'hA5; data7 = 7'h25;
    bad = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk50m);
      if (txd_v !== 4'hF || busy_v !== 4'h0 || ready_v !== 4'hF) bad++;
    end
    chk("reset hold bad clocks", 32'(bad), 32'd0);
    valid_v = 4'h0;
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk50m);
      if (txd_v !== 4'hF || busy_v !== 4'h0 || ready_v !== 4'hF) bad++;
    end
    chk("after release bad clocks", 32'(bad), 32'd0);
    $display("reset hold 500 clks with valid high, released idle");

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].sel, vecs[i].data, vecs[i].frame, vecs[i].nbits, vecs[i].tag);
    end

    // Back-to-back with tx_valid level-held: 0x48 then 0x49, no gap.
    b2b = {10'h292, 10'h290};
    m1 = 0; m2 = 0; busy_errs = 0; ready_errs = 0;
    @(negedge clk50m);
    data_a[0]  = 8'h48;
    valid_v[0] = 1'b1;
    @(posedge clk50m);
    for (int k = 0; k < 20 * CPB; k++) begin
      @(negedge clk50m);
      if (k == 0) data_a[0] = 8'h49;
      if (k == 10 * CPB) valid_v[0] = 1'b0;
      if (txd_v[0] === b2b[k / CPB]) begin
        if (k < 10 * CPB) m1++;
        else m2++;
      end
      if (busy_v[0] !== 1'b1) busy_errs++;
      if (ready_v[0] !== ((k == 10 * CPB - 1) || (k == 20 * CPB - 1))) ready_errs++;
    end
    chk("b2b frame1 clocks matching", 32'(m1), 32'(10 * CPB));
    chk("b2b frame2 clocks matching", 32'(m2), 32'(10 * CPB));
    chk("b2b busy errors", 32'(busy_errs), 32'd0);
    chk("b2b ready errors", 32'(ready_errs), 32'd0);
    bad = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk50m);
      if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
    end
    chk("b2b no third frame", 32'(bad), 32'd0);
    $display("back-to-back 0x48,0x49 clks=%0d", 20 * CPB);

    // Reset pulse in the middle of data bit 3 of 0x00.
    @(negedge clk50m);
    data_a[0]  = 8'h00;
    valid_v[0] = 1'b1;
    @(posedge clk50m);
    for (int k = 0; k <= 4 * CPB + 200; k++) begin
      @(negedge clk50m);
      if (k == 0) valid_v[0] = 1'b0;
    end
    chk("mid-frame txd before reset", 32'(txd_v[0]), 32'd0);
    #2 reset_n = 1'b0;
    #1 chk("reset abort {txd,busy,ready}",
           32'({txd_v[0], busy_v[0], ready_v[0]}), 32'b101);
    repeat (3) @(negedge clk50m);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk50m);
      if ({txd_v[0], busy_v[0], ready_v[0]} !== 3'b101) bad++;
    end
    chk("post-abort idle bad clocks", 32'(bad), 32'd0);
    $display("reset pulse during data bit 3 aborted frame");
    run_frame(0, 8'h00, 12'h200, 10, "8N1_00_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
